// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder walks the operands LSB first over WIDTH cycles,
// with a valid/ready handshake on both the operand and the result side.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic           carry;
    logic           c_msb;
    logic [CW-1:0]  cnt;
    logic           fa_s;
    logic           fa_co;
    logic           accept;
    logic           run_step;
    logic           last_bit;
    logic           msb_m1_bit;

    assign accept     = (state == IDLE) && in_valid;
    assign run_step   = (state == RUN);
    assign last_bit   = (cnt == CW'(WIDTH - 1));
    assign msb_m1_bit = (cnt == CW'(WIDTH - 2));

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status decodes of the registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Serial datapath; result registers load only on the final bit and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (run_step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            if (msb_m1_bit) begin
                c_msb <= fa_co;
            end
            if (last_bit) begin
                sum  <= {fa_s, sum_sh[WIDTH-1:1]};
                cout <= fa_co;
                ovf  <= c_msb ^ fa_co;
            end
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port in_valid, input, 1 bit: operand set a, b, cin is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: block can accept an operand set.
REQ-006 The module SHALL have port a, input, WIDTH bits: addend A, unsigned or two's complement.
REQ-007 The module SHALL have port b, input, WIDTH bits: addend B.
REQ-008 The module SHALL have port cin, input, 1 bit: carry-in for bit 0.
REQ-009 The module SHALL have port out_valid, output, 1 bit: sum, cout and ovf are valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The module SHALL have port sum, output, WIDTH bits: a + b + cin, modulo 2^WIDTH.
REQ-012 The module SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-013 The module SHALL have port ovf, output, 1 bit: signed overflow, i.e. carry into MSB XOR carry out of MSB.
REQ-014 The module SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-015 The module SHALL compute the sum bit-serially with exactly one full_adder instance, which is the only adder logic in the block.
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL equal (state == IDLE), and out_valid SHALL equal (state == DONE); both are registered-state decodes with no combinational path from in_valid or out_ready.
REQ-018 On the IDLE clock edge where in_valid=1, the block SHALL capture a and b into shift registers, load the carry flop with cin, clear the bit counter, and enter RUN.
REQ-019 Each RUN cycle SHALL process one bit, LSB first:
  - full adder operands: a_sh[0], b_sh[0], carry flop;
  - a_sh and b_sh shift right by one;
  - the sum bit shifts into sum_sh[WIDTH-1] and sum_sh shifts right;
  - the carry flop takes the full-adder carry;
  - the counter increments.
REQ-020 On the RUN edge that processes bit WIDTH-2, the module SHALL save the carry flop's next value as the carry into the MSB (c_msb).
REQ-021 On the RUN edge that processes bit WIDTH-1, the module SHALL enter DONE, with cout = final carry and ovf = c_msb XOR final carry.
REQ-022 Latency SHALL be exactly WIDTH clock edges from the accept edge to the edge that raises out_valid; throughput SHALL be one operation per WIDTH+2 cycles at best.
REQ-023 In DONE, sum, cout and ovf SHALL hold stable until the handshake edge where out_ready=1, after which the state SHALL return to IDLE.
REQ-024 In DONE, the module SHALL remain in DONE indefinitely while out_ready=0.
REQ-025 in_valid, a, b and cin SHALL be ignored in RUN and DONE, and operand changes after the accept edge SHALL NOT affect the result.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap during an operation.
REQ-028 sum, cout and ovf SHALL be undefined-free (hold their last values) outside DONE, and consumers SHALL qualify them with out_valid.

Reset
REQ-029 When rst_n=0, the module SHALL immediately, independent of clk, set:
  - state = IDLE;
  - counter, shift registers, carry flop, c_msb, sum, cout and ovf = 0;
  - in_ready = 1, out_valid = 0, busy = 0.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation with no result presented; the first accept after release SHALL start a fresh operation.
REQ-031 After rst_n deasserts, the first rising clk edge SHALL accept in_valid normally.

Verification (WIDTH=8)
REQ-032 a=0x5A, b=0x3C, cin=0 -> out_valid 8 edges after accept; sum=0x96, cout=0, ovf=1.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> sum, cout, ovf and out_valid stable for all 5 cycles; IDLE on the cycle after out_ready=1.
REQ-035 in_valid held 1 with changing a and b during RUN -> no second accept; the result matches the first operands; the next accept occurs only in IDLE.
REQ-036 rst_n pulsed low at RUN bit 4 -> immediate IDLE with all outputs 0; a new 0x01+0x01 operation then yields sum=0x02.
REQ-037 Random back-to-back operations (1000, random out_ready stalls) SHALL match a reference model of {cout,sum} = a+b+cin and ovf = (a[7]==b[7]) && (sum[7]!=a[7]).
